// File: rtl/pcie_cq_desc_capture.sv
// CQ descriptor capture: passes the Completer Request stream through untouched
// and records one compact 80-bit descriptor per TLP into a show-ahead FIFO.
//
// state  | meaning
// IDLE   | between TLPs, waiting for a start-of-packet beat
// IN_PKT | SOP seen without tlast; fields held, counting beats until tlast
module pcie_cq_desc_capture #(
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int AXIS_TUSER_WIDTH = 228,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    output logic                          s_axis_tready,

    output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    input  logic                          m_axis_tready,

    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [79:0]                   rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_cnt,
    output logic [7:0]                    err_cnt
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int DESC_W = 71;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                beat, sop;
    logic [DESC_W-1:0]   cur_desc, hold_desc;
    logic [7:0]          beat_cnt_q, beat_cnt_inc;
    logic                trunc_q, trunc_inc;
    logic                push, latch, cnt_inc, err_inc;
    logic [79:0]         push_rec;
    logic                push_ok, pop;

    logic [79:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0]    level_q;
    logic [7:0]          drop_q, err_q;

    // Stream is a pure wire-through; capture never stalls it.
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tvalid = s_axis_tvalid;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tuser  = s_axis_tuser;
    assign s_axis_tready = m_axis_tready;

    assign beat = s_axis_tvalid & m_axis_tready;
    assign sop  = beat & (s_axis_tuser[81:80] != 2'b00);

    // Descriptor layout: type, dword count, tag, requester, dword-aligned address.
    assign cur_desc = {s_axis_tdata[78:75], s_axis_tdata[74:64], s_axis_tdata[103:96],
                       s_axis_tdata[95:80], s_axis_tdata[31:2], 2'b00};

    assign beat_cnt_inc = (beat_cnt_q == 8'hFF) ? 8'hFF : beat_cnt_q + 8'd1;
    assign trunc_inc    = trunc_q | (beat_cnt_q == 8'hFF);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state, record push and holding-register control.
    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        push_rec = '0;
        latch    = 1'b0;
        cnt_inc  = 1'b0;
        err_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sop) begin
                    if (s_axis_tlast) begin
                        push     = 1'b1;
                        push_rec = {cur_desc, 8'd1, 1'b0};
                    end else begin
                        latch   = 1'b1;
                        state_d = IN_PKT;
                    end
                end
            end
            IN_PKT: begin
                if (sop) begin
                    // A new SOP abandons the held TLP; restart from this beat.
                    err_inc = 1'b1;
                    if (s_axis_tlast) begin
                        push     = 1'b1;
                        push_rec = {cur_desc, 8'd1, 1'b0};
                        state_d  = IDLE;
                    end else begin
                        latch = 1'b1;
                    end
                end else if (beat) begin
                    cnt_inc = 1'b1;
                    if (s_axis_tlast) begin
                        push     = 1'b1;
                        push_rec = {hold_desc, beat_cnt_inc, trunc_inc};
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register and saturating beat counter for multi-beat TLPs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_desc  <= '0;
            beat_cnt_q <= '0;
            trunc_q    <= 1'b0;
        end else if (latch) begin
            hold_desc  <= cur_desc;
            beat_cnt_q <= 8'd1;
            trunc_q    <= 1'b0;
        end else if (cnt_inc) begin
            beat_cnt_q <= beat_cnt_inc;
            trunc_q    <= trunc_inc;
        end
    end

    assign pop     = rd_en & rd_valid;
    assign push_ok = push & ((level_q != DEPTH_LVL) | pop);

    // Record storage; no reset needed, contents are only visible when non-empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_rec;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Saturating drop and framing-error counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_q <= '0;
            err_q  <= '0;
        end else begin
            if (push && !push_ok && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            if (err_inc && err_q != 8'hFF)           err_q  <= err_q + 8'd1;
        end
    end

    assign rd_valid   = (level_q != '0);
    assign rd_data    = mem[rd_ptr];
    assign fifo_level = level_q;
    assign drop_cnt   = drop_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_pcie_cq_desc_capture.sv
// Bench for pcie_cq_desc_capture: packet-level stimulus with a queue model of the
// record FIFO; a negedge monitor pops expected records as the DUT pops them.
module tb_pcie_cq_desc_capture;

    localparam int DW    = 512;
    localparam int UW    = 228;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tvalid, s_tlast, s_tready;
    logic [UW-1:0] s_tuser;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid, m_tlast, m_tready;
    logic [UW-1:0] m_tuser;
    logic          rd_en, rd_valid;
    logic [79:0]   rd_data;
    logic [LW-1:0] fifo_level;
    logic [7:0]    drop_cnt, err_cnt;

    pcie_cq_desc_capture #(.AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [79:0] exp_q[$];
    int          m_drop = 0, m_err = 0;
    int          snap_level = 0, snap_drop = 0, snap_err = 0;
    bit          in_pkt = 0;
    bit          mon_en = 0;
    int          rd_mode = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: per-cycle status against model snapshot, record pops against the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("fifo_level", fifo_level, snap_level);
            chk("rd_valid", rd_valid, snap_level != 0);
            chk("drop_cnt", drop_cnt, snap_drop);
            chk("err_cnt", err_cnt, snap_err);
            chk("s_tready", s_tready, m_tready);
            checks++;
            if (m_tdata !== s_tdata || m_tkeep !== s_tkeep || m_tuser !== s_tuser ||
                m_tvalid !== s_tvalid || m_tlast !== s_tlast) begin
                errors++;
                $display("FAIL passthrough: m_tvalid=%0b m_tlast=%0b expected %0b %0b (or data/user/keep differ)",
                         m_tvalid, m_tlast, s_tvalid, s_tlast);
            end
            if (rd_en && rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_data: got %0h expected no record", rd_data);
                end else begin
                    chk("rd_data", rd_data, exp_q.pop_front());
                end
            end
        end
    end

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic get_re();
        if (rd_mode == 2) return 1'b1;
        if (rd_mode == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    // One clock cycle of stimulus, called just after a rising edge. The model
    // applies what the coming edge does: error count, then FIFO push/drop.
    task automatic step(input logic v, input logic rdy, input logic last, input logic [1:0] sopf,
                        input logic [DW-1:0] d, input logic re, input bit push_it,
                        input logic [79:0] rec, input bit err_it);
        logic [255:0] u;
        snap_level = exp_q.size();
        snap_drop  = m_drop;
        snap_err   = m_err;
        for (int i = 0; i < 8; i++) u[i*32 +: 32] = $urandom();
        u[81:80]  = sopf;
        s_tuser   = u[UW-1:0];
        s_tkeep   = {$urandom(), $urandom()};
        s_tvalid  = v;
        m_tready  = rdy;
        s_tlast   = last;
        s_tdata   = d;
        rd_en     = re;
        if (err_it && m_err < 255) m_err++;
        if (push_it) begin
            if (exp_q.size() < DEPTH || (re && exp_q.size() > 0)) exp_q.push_back(rec);
            else if (m_drop < 255) m_drop++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic re);
        repeat (n) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 2'b00, rnd_data(), re, 1'b0, '0, 1'b0);
    endtask

    // Sends one TLP. Expected record follows the capture rules: SOP fields,
    // beat count min(n,255), trunc when more than 255 beats were accepted.
    task automatic send_tlp(input logic [3:0] typ, input logic [10:0] dw, input logic [7:0] tag,
                            input logic [15:0] rid, input logic [31:0] addr, input int nbeats,
                            input bit has_last, input int stall_beat, input int stall_len,
                            input int bp_pct);
        logic [DW-1:0] d;
        logic [79:0]   rec;
        logic [1:0]    sopf;
        logic          last_b;
        int            bc, waited, r;
        bc  = (nbeats > 255) ? 255 : nbeats;
        rec = {typ, dw, tag, rid, addr[31:2], 2'b00, 8'(bc), 1'(nbeats > 255)};
        for (int b = 0; b < nbeats; b++) begin
            last_b = has_last && (b == nbeats - 1);
            d      = rnd_data();
            sopf   = 2'b00;
            if (b == 0) begin
                d[78:75]  = typ;
                d[74:64]  = dw;
                d[95:80]  = rid;
                d[103:96] = tag;
                d[31:0]   = addr;
                sopf      = 2'($urandom_range(1, 3));
            end
            if (b == stall_beat) repeat (stall_len) step(1'b1, 1'b0, last_b, sopf, d, get_re(), 1'b0, rec, 1'b0);
            waited = 0;
            while (bp_pct > 0 && $urandom_range(0, 99) < bp_pct && waited < 50) begin
                r = $urandom_range(0, 2);
                step(1'(r == 1), 1'(r == 2), last_b, sopf, d, get_re(), 1'b0, rec, 1'b0);
                waited++;
            end
            step(1'b1, 1'b1, last_b, sopf, d, get_re(), last_b, rec, (b == 0) && in_pkt);
            if (b == 0) in_pkt = 1;
            if (last_b) in_pkt = 0;
        end
    endtask

    task automatic single(input logic [7:0] tag);
        send_tlp(4'($urandom()), 11'($urandom()), tag, 16'($urandom()), $urandom(), 1, 1, -1, 0, 0);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            idle(1, 1'b1);
            guard++;
        end
        chk("drain_remaining", 80'(exp_q.size()), 80'd0);
        idle(1, 1'b0);
    endtask

    task automatic do_reset();
        mon_en   = 0;
        rst      = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        rd_en    = 1'b0;
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_drop     = 0;
        m_err      = 0;
        in_pkt     = 0;
        snap_level = 0;
        snap_drop  = 0;
        snap_err   = 0;
        mon_en     = 1;
    endtask

    initial begin
        s_tdata = '0; s_tkeep = '0; s_tuser = '0;
        do_reset();
        #2;
        chk("reset_level", fifo_level, 0);
        chk("reset_valid", rd_valid, 0);
        chk("reset_drop", drop_cnt, 0);
        chk("reset_err", err_cnt, 0);

        // Single-beat MemRd.
        rd_mode = 0;
        send_tlp(4'h0, 11'd1, 8'h12, 16'h0100, 32'h1000_0004, 1, 1, -1, 0, 0);
        idle(1, 1'b0);
        #2;
        chk("memrd_level", fifo_level, 1);
        chk("memrd_rec", rd_data, {4'h0, 11'd1, 8'h12, 16'h0100, 32'h1000_0004, 8'd1, 1'b0});
        idle(1, 1'b1);
        idle(1, 1'b0);
        #2;
        chk("memrd_popped", rd_valid, 0);

        // Three-beat MemWr with two stalled cycles mid-packet.
        send_tlp(4'h1, 11'd32, 8'h34, 16'h0200, 32'h2000_0010, 3, 1, 1, 2, 0);
        idle(1, 1'b0);
        #2;
        chk("memwr_type_beats", {rd_data[79:76], rd_data[8:0]}, {4'h1, 8'd3, 1'b0});
        drain();

        // Overflow: 20 records, 16 kept, 4 dropped, read back in order.
        for (int i = 0; i < 20; i++) single(8'(i));
        idle(1, 1'b0);
        #2;
        chk("full_level", fifo_level, 16);
        chk("full_drop", drop_cnt, 4);
        drain();

        // Full FIFO with a pop on the same edge as a push.
        for (int i = 0; i < 16; i++) single(8'(8'h40 + i));
        rd_mode = 2;
        single(8'h77);
        rd_mode = 0;
        idle(1, 1'b0);
        #2;
        chk("pushpop_level", fifo_level, 16);
        chk("pushpop_drop", drop_cnt, 4);
        drain();

        // Abandoned TLP then a single-beat one.
        send_tlp(4'h2, 11'd4, 8'hA0, 16'h0300, 32'h3000_0000, 1, 0, -1, 0, 0);
        single(8'hA1);
        idle(1, 1'b0);
        #2;
        chk("abandon_err", err_cnt, 1);
        chk("abandon_level", fifo_level, 1);
        chk("abandon_tag", rd_data[64:57], 8'hA1);
        drain();

        // 300-beat TLP saturates the beat count.
        send_tlp(4'h1, 11'd1024, 8'hB0, 16'h0400, 32'h4000_0008, 300, 1, -1, 0, 0);
        idle(1, 1'b0);
        #2;
        chk("long_beats", rd_data[8:0], {8'hFF, 1'b1});
        drain();

        // Reset mid-packet with three records held.
        for (int i = 0; i < 3; i++) single(8'(8'hC0 + i));
        send_tlp(4'h1, 11'd8, 8'hC8, 16'h0500, 32'h5000_0000, 2, 0, -1, 0, 0);
        do_reset();
        #2;
        chk("midrst_level", fifo_level, 0);
        chk("midrst_valid", rd_valid, 0);
        chk("midrst_err", err_cnt, 0);
        chk("midrst_drop", drop_cnt, 0);
        step(1'b1, 1'b1, 1'b1, 2'b00, rnd_data(), 1'b0, 1'b0, '0, 1'b0);
        idle(2, 1'b0);
        #2;
        chk("stray_level", fifo_level, 0);
        chk("stray_err", err_cnt, 0);

        // Randomized traffic with backpressure, abandons and stray beats.
        for (int n = 0; n < 250; n++) begin
            int nb;
            rd_mode = $urandom_range(0, 2);
            nb = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 20) : $urandom_range(1, 5);
            if (!in_pkt && $urandom_range(0, 9) == 0)
                step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 2'b00, rnd_data(), get_re(), 1'b0, '0, 1'b0);
            send_tlp(4'($urandom()), 11'($urandom()), 8'($urandom()), 16'($urandom()), $urandom(),
                     nb, $urandom_range(0, 9) != 0, -1, 0, 30);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), get_re());
        end
        rd_mode = 0;
        drain();

        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcie_cq_desc_capture.md
Name: pcie_cq_desc_capture

Overview:
- Sits directly downstream of the CQ transaction-type counter on the PCIe Completer Request AXI-stream.
- Passes the stream through transparently.
- For each TLP, captures a compact descriptor record (type, length, tag, requester, address, beat count) into a small show-ahead FIFO. The FIFO is read by debug/ILA or register logic.
- Also counts dropped records and framing errors.

Parameters:
- AXIS_DATA_WIDTH, 512, CQ tdata width; tkeep width is AXIS_DATA_WIDTH/8.
- AXIS_TUSER_WIDTH, 228, CQ tuser width.
- FIFO_DEPTH, 16, record FIFO entries; power of two, 2..256.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- s_axis_tdata/tkeep/tvalid/tlast/tuser  in  per params  CQ stream in
- s_axis_tready  out  1  equals m_axis_tready
- m_axis_tdata/tkeep/tvalid/tlast/tuser  out  per params  combinational copy of s_axis_*
- m_axis_tready  in  1  downstream ready
- rd_en  in  1  pop the head record when rd_valid=1
- rd_valid  out  1  FIFO non-empty
- rd_data  out  80  head record (show-ahead)
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- drop_cnt  out  8  records lost to full FIFO; saturates at 0xFF
- err_cnt  out  8  TLPs abandoned by SOP without prior tlast; saturates at 0xFF

Behaviour:
- Reset: rst=0 at a clk edge clears:
  - state to IDLE;
  - FIFO pointers and fifo_level to 0 (rd_valid=0);
  - drop_cnt and err_cnt to 0;
  - the holding register and the beat counter.
  - rd_data is undefined while empty.
  - Reset mid-packet discards the partial record.
- Beat accept: beat = s_axis_tvalid & m_axis_tready. SOP: beat & (s_axis_tuser[81:80] != 0).
- Descriptor fields are taken from the SOP beat:
  - req_type = tdata[78:75]
  - dword_count = tdata[74:64]
  - requester_id = tdata[95:80]
  - tag = tdata[103:96]
  - addr_lo = tdata[31:0], with bits [1:0] forced to 0.
- Record layout (rd_data):
  - [79:76] req_type
  - [75:65] dword_count
  - [64:57] tag
  - [56:41] requester_id
  - [40:9] addr_lo
  - [8:1] beat_count
  - [0] trunc
- beat_count is the number of accepted beats including SOP and tlast. It saturates at 255, and trunc=1 if saturation occurred.
- FSM states: IDLE, IN_PKT.
  - IDLE, SOP & tlast: single-beat TLP. Push the record from the current beat, beat_count=1. Stay in IDLE.
  - IDLE, SOP & !tlast: latch fields, beat counter=1. Go to IN_PKT.
  - IDLE, beat without SOP: ignore. No count, no error.
  - IN_PKT, beat without SOP: increment the beat counter (saturating). If tlast, push the record and go to IDLE.
  - IN_PKT, SOP: increment err_cnt and discard the held record. Then treat the beat as the IDLE SOP case (push if tlast, else re-latch and stay in IN_PKT).
- Latency: a record is pushed on the clk edge that accepts the tlast beat. rd_valid and rd_data reflect it on the next cycle.
- FIFO:
  - Pop occurs when rd_en & rd_valid; rd_en while empty is ignored.
  - A push succeeds if fifo_level < FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the record is dropped and drop_cnt increments (saturating).
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Backpressure: beats with m_axis_tready=0 are not counted. Capture never stalls the stream.

Test Plan:
- Reset, then one single-beat MemRd (req_type=0, dword_count=1, tag=0x12, req_id=0x0100, addr=0x1000_0004, sop=01, tlast=1) -> next cycle rd_valid=1, rd_data decodes to those values, beat_count=1, trunc=0, fifo_level=1. rd_en -> rd_valid=0.
- MemWr with dword_count=32 over 3 beats, m_axis_tready deasserted for 2 cycles mid-packet -> one record, req_type=1, beat_count=3.
- 20 single-beat TLPs with no reads, FIFO_DEPTH=16 -> fifo_level=16, drop_cnt=4. Popping all 16 returns tags in order.
- FIFO full and rd_en=1 on the same cycle as a tlast push -> record accepted, fifo_level stays 16, drop_cnt unchanged.
- SOP, 1 beat, then a new SOP with tlast before any tlast -> err_cnt=1, only the second TLP recorded. A 300-beat TLP -> beat_count=255, trunc=1.
- rst=0 asserted mid-packet (IN_PKT, FIFO holding 3 records) -> all counters 0, rd_valid=0. A subsequent non-SOP tlast beat is ignored.
